clint_irq_src: RTL and testbench

Machine-mode interrupt source block: generates the machine software (MSIP), timer (MTIP) and external (MEIP) pending levels that the CPU's mode/interrupt logic samples via the mip CSR. It holds a 64-bit free-running mtime counter with prescaler, a 64-bit mtimecmp compare register and the msip bit, all memory-mapped on a simple word-wide request/acknowledge bus. It also synchronizes the asynchronous external interrupt pin.

---
 rtl/clint_irq_src_if.sv | 19 +
 rtl/clint_irq_src.sv | 119 +++++++++++
 tb/tb_clint_irq_src.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_irq_src_if.sv
// rtl/clint_irq_src_if.sv - word-wide request/acknowledge register bus
interface clint_irq_src_if;
  logic        bus_req;
  logic        bus_wr;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/clint_irq_src.sv
// rtl/clint_irq_src.sv - machine-mode msip/mtip/meip source with mtime/mtimecmp
module clint_irq_src #(
  parameter int TICK_DIV    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_in,
  input  logic           reset_in,
  clint_irq_src_if.slave bus,
  input  logic           ext_irq_pin,
  output logic           msip,
  output logic           mtip,
  output logic           meip
);
  localparam logic [15:0] TICK_MAX  = 16'(TICK_DIV - 1);
  localparam logic [13:0] A_MSIP    = 14'h0000;
  localparam logic [13:0] A_CMP_LO  = 14'h1000;
  localparam logic [13:0] A_CMP_HI  = 14'h1001;
  localparam logic [13:0] A_TIME_LO = 14'h2FFE;
  localparam logic [13:0] A_TIME_HI = 14'h2FFF;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t                 r_state;
  logic [15:0]            r_presc;
  logic [63:0]            r_mtime;
  logic [63:0]            r_mtimecmp;
  logic                   r_msip;
  logic                   r_mtip;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ack;
  logic [31:0]            r_rdata;

  logic [13:0] w_word;
  logic        w_wr;
  logic        w_tick;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_word        = bus.bus_addr[15:2];
  assign w_unused_addr = ^bus.bus_addr[1:0];
  assign w_wr          = (r_state == S_IDLE) && bus.bus_req && bus.bus_wr;
  assign w_tick        = (r_presc == TICK_MAX);

  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      A_MSIP:    w_rdata = {31'd0, r_msip};
      A_CMP_LO:  w_rdata = r_mtimecmp[31:0];
      A_CMP_HI:  w_rdata = r_mtimecmp[63:32];
      A_TIME_LO: w_rdata = r_mtime[31:0];
      A_TIME_HI: w_rdata = r_mtime[63:32];
      default:   w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_presc    <= 16'd0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= {64{1'b1}};
      r_msip     <= 1'b0;
      r_mtip     <= 1'b0;
      r_sync     <= '0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      // A software write to either half wins over the tick; the other half holds without carry.
      if (w_wr && (w_word == A_TIME_LO)) begin
        r_mtime[31:0] <= bus.bus_wdata;
      end else if (w_wr && (w_word == A_TIME_HI)) begin
        r_mtime[63:32] <= bus.bus_wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_wr && (w_word == A_CMP_LO)) r_mtimecmp[31:0]  <= bus.bus_wdata;
      if (w_wr && (w_word == A_CMP_HI)) r_mtimecmp[63:32] <= bus.bus_wdata;
      if (w_wr && (w_word == A_MSIP))   r_msip            <= bus.bus_wdata[0];
      r_mtip <= (r_mtime >= r_mtimecmp);
      r_sync <= {r_sync[SYNC_STAGES-2:0], ext_irq_pin};
    end
  end

  // WAIT holds off until bus_req drops so a held request is serviced only once.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.bus_req) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_rdata <= bus.bus_wr ? 32'd0 : w_rdata;
          end
        end
        S_ACK: begin
          r_state <= S_WAIT;
          r_ack   <= 1'b0;
          r_rdata <= 32'd0;
        end
        S_WAIT: begin
          if (!bus.bus_req) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_rdata <= 32'd0;
        end
      endcase
    end
  end

  assign bus.bus_ack   = r_ack;
  assign bus.bus_rdata = r_rdata;
  assign msip          = r_msip;
  assign mtip          = r_mtip;
  assign meip          = r_sync[SYNC_STAGES-1];
endmodule

// File: tb/tb_clint_irq_src.sv
// tb/tb_clint_irq_src.sv - directed bench for clint_irq_src (TICK_DIV=1 and TICK_DIV=4 instances)
module tb_clint_irq_src;
  logic        clk;
  logic        rst;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        pin;
  logic        msip1, mtip1, meip1;
  logic        msip4, mtip4, meip4;
  logic [31:0] rd1, rd4;
  int          checks;
  int          errors;
  int          cyc;

  clint_irq_src_if b1 ();
  clint_irq_src_if b4 ();

  assign b1.bus_req   = req;
  assign b1.bus_wr    = wr;
  assign b1.bus_addr  = addr;
  assign b1.bus_wdata = wdata;
  assign b4.bus_req   = req;
  assign b4.bus_wr    = wr;
  assign b4.bus_addr  = addr;
  assign b4.bus_wdata = wdata;

  clint_irq_src #(.TICK_DIV(1), .SYNC_STAGES(2)) dut1 (
    .clk_in(clk), .reset_in(rst), .bus(b1.slave), .ext_irq_pin(pin),
    .msip(msip1), .mtip(mtip1), .meip(meip1)
  );

  clint_irq_src #(.TICK_DIV(4), .SYNC_STAGES(3)) dut4 (
    .clk_in(clk), .reset_in(rst), .bus(b4.slave), .ext_irq_pin(pin),
    .msip(msip4), .mtip(mtip4), .meip(meip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since reset release; with TICK_DIV=4 a tick lands on every posedge where cyc becomes a multiple of 4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic bus_access(input logic w, input logic [15:0] a, input logic [31:0] d);
    int n;
    req = 1'b1; wr = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b1.bus_ack && n < 10);
    checks++;
    if (b1.bus_ack !== 1'b1 || b4.bus_ack !== 1'b1) begin
      errors++;
      $display("FAIL bus_ack_timeout addr=%h got %b/%b exp 1", a, b1.bus_ack, b4.bus_ack);
    end
    rd1 = b1.bus_rdata;
    rd4 = b4.bus_rdata;
    req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    bus_access(1'b1, 16'h0000, 32'h1);
    req = 1'b1; wr = 1'b0; addr = 16'h4000;
    @(posedge clk); #2;
    checks++;
    if (b1.bus_ack !== 1'b1) begin errors++; $display("FAIL pre_reset_ack got %b exp 1", b1.bus_ack); end
    rst = 1'b1; #1;
    checks++;
    if ({b1.bus_ack, b4.bus_ack, msip1, msip4, mtip1, mtip4, meip1, meip4} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_outputs got %b exp 00000000",
               {b1.bus_ack, b4.bus_ack, msip1, msip4, mtip1, mtip4, meip1, meip4});
    end
    checks++;
    if (b1.bus_rdata !== 32'd0 || b4.bus_rdata !== 32'd0) begin
      errors++; $display("FAIL async_reset_rdata got %h/%h exp 0", b1.bus_rdata, b4.bus_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.bus_ack !== 1'b1 || b1.bus_rdata !== 32'hFFFF_FFFF || b4.bus_rdata !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL held_req_after_reset got ack=%b rdata=%h/%h exp ack=1 rdata=ffffffff",
               b1.bus_ack, b1.bus_rdata, b4.bus_rdata);
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    bus_access(1'b0, 16'hBFF8, 32'd0);
    checks++;
    if (rd1 !== 32'd3 || rd4 !== 32'd0) begin
      errors++; $display("FAIL reset_mtime_lo got %h/%h exp 3/0", rd1, rd4);
    end
    bus_access(1'b0, 16'hBFFC, 32'd0);
    checks++;
    if (rd1 !== 32'd0 || rd4 !== 32'd0) begin errors++; $display("FAIL reset_mtime_hi got %h/%h exp 0", rd1, rd4); end
    bus_access(1'b0, 16'h4004, 32'd0);
    checks++;
    if (rd1 !== 32'hFFFF_FFFF || rd4 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_mtimecmp_hi got %h/%h exp ffffffff", rd1, rd4);
    end
    bus_access(1'b0, 16'h0000, 32'd0);
    checks++;
    if (rd1 !== 32'd0 || rd4 !== 32'd0) begin errors++; $display("FAIL reset_msip_read got %h/%h exp 0", rd1, rd4); end
  endtask

  task automatic test_timer;
    bus_access(1'b1, 16'hBFFC, 32'd0);
    bus_access(1'b1, 16'hBFF8, 32'd10);
    bus_access(1'b1, 16'h4004, 32'd0);
    bus_access(1'b1, 16'h4000, 32'd20);
    checks++;
    if (mtip1 !== 1'b0) begin errors++; $display("FAIL mtip_at_18 got %b exp 0", mtip1); end
    @(negedge clk);
    checks++;
    if (mtip1 !== 1'b0) begin errors++; $display("FAIL mtip_at_19 got %b exp 0", mtip1); end
    @(negedge clk);
    checks++;
    if (mtip1 !== 1'b0) begin errors++; $display("FAIL mtip_at_20 got %b exp 0", mtip1); end
    @(negedge clk);
    checks++;
    if (mtip1 !== 1'b1) begin errors++; $display("FAIL mtip_rise got %b exp 1", mtip1); end
    bus_access(1'b0, 16'hBFF8, 32'd0);
    checks++;
    if (rd1 !== 32'd21) begin errors++; $display("FAIL timer_mtime_lo got %h exp 15", rd1); end
    req = 1'b1; wr = 1'b1; addr = 16'h4004; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (b1.bus_ack !== 1'b1 || mtip1 !== 1'b1) begin
      errors++; $display("FAIL mtip_hold_on_cmp_write got ack=%b mtip=%b exp 1/1", b1.bus_ack, mtip1);
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (mtip1 !== 1'b0) begin errors++; $display("FAIL mtip_fall got %b exp 0", mtip1); end
    @(negedge clk);
  endtask

  task automatic test_prescaler_wrap;
    int e, rise, fall, exp_rise;
    bus_access(1'b1, 16'h4000, 32'hFFFF_FFFF);
    bus_access(1'b1, 16'hBFFC, 32'hFFFF_FFFF);
    bus_access(1'b1, 16'hBFF8, 32'hFFFF_FFFE);
    e = cyc - 2;
    exp_rise = 3 - (e % 4);
    rise = -1; fall = -1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        checks++;
        if (mtip1 !== 1'b1) begin errors++; $display("FAIL div1_mtip_at_max got %b exp 1", mtip1); end
      end
      if (i == 1) begin
        checks++;
        if (mtip1 !== 1'b0) begin errors++; $display("FAIL div1_mtip_after_wrap got %b exp 0", mtip1); end
      end
      if (rise < 0 && mtip4 === 1'b1) rise = i;
      else if (rise >= 0 && fall < 0 && mtip4 === 1'b0) fall = i;
      @(negedge clk);
    end
    checks++;
    if (rise !== exp_rise) begin errors++; $display("FAIL div4_mtip_rise got %0d exp %0d", rise, exp_rise); end
    checks++;
    if (fall !== exp_rise + 4) begin errors++; $display("FAIL div4_mtip_fall got %0d exp %0d", fall, exp_rise + 4); end
    bus_access(1'b0, 16'hBFFC, 32'd0);
    checks++;
    if (rd1 !== 32'd0 || rd4 !== 32'd0) begin errors++; $display("FAIL wrap_mtime_hi got %h/%h exp 0", rd1, rd4); end
  endtask

  task automatic test_collision;
    bus_access(1'b1, 16'hBFFC, 32'h55);
    while ((cyc + 1) % 4 != 0) @(negedge clk);
    bus_access(1'b1, 16'hBFF8, 32'h1234);
    bus_access(1'b0, 16'hBFF8, 32'd0);
    checks++;
    if (rd4 !== 32'h1234 || rd1 !== 32'h1236) begin
      errors++; $display("FAIL collision_lo got %h/%h exp 1236/1234", rd1, rd4);
    end
    bus_access(1'b0, 16'hBFFC, 32'd0);
    checks++;
    if (rd1 !== 32'h55 || rd4 !== 32'h55) begin errors++; $display("FAIL collision_hi got %h/%h exp 55", rd1, rd4); end
    bus_access(1'b0, 16'hBFF8, 32'd0);
    checks++;
    if (rd4 !== 32'h1236) begin errors++; $display("FAIL collision_later_ticks got %h exp 1236", rd4); end
  endtask

  task automatic test_msip;
    bus_access(1'b1, 16'h0000, 32'h3);
    checks++;
    if (msip1 !== 1'b1 || msip4 !== 1'b1) begin errors++; $display("FAIL msip_set got %b/%b exp 1", msip1, msip4); end
    bus_access(1'b0, 16'h0000, 32'd0);
    checks++;
    if (rd1 !== 32'h1) begin errors++; $display("FAIL msip_read got %h exp 1", rd1); end
    bus_access(1'b1, 16'h0000, 32'h0);
    checks++;
    if (msip1 !== 1'b0 || msip4 !== 1'b0) begin errors++; $display("FAIL msip_clear got %b/%b exp 0", msip1, msip4); end
  endtask

  task automatic test_meip;
    logic lvl;
    for (int p = 0; p < 2; p++) begin
      lvl = (p == 0);
      pin = lvl;
      @(negedge clk);
      checks++;
      if (meip1 !== !lvl || meip4 !== !lvl) begin
        errors++; $display("FAIL meip_edge1 got %b/%b exp %b", meip1, meip4, !lvl);
      end
      @(negedge clk);
      checks++;
      if (meip1 !== lvl || meip4 !== !lvl) begin
        errors++; $display("FAIL meip_edge2 got %b/%b exp %b/%b", meip1, meip4, lvl, !lvl);
      end
      @(negedge clk);
      checks++;
      if (meip4 !== lvl) begin errors++; $display("FAIL meip_edge3 got %b exp %b", meip4, lvl); end
    end
  endtask

  task automatic test_back_to_back;
    int acks;
    acks = 0;
    req = 1'b1; wr = 1'b0; addr = 16'h4007;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b1.bus_ack === 1'b1) acks++;
      checks++;
      if (b1.bus_rdata !== (b1.bus_ack === 1'b1 ? 32'hFFFF_FFFF : 32'd0)) begin
        errors++; $display("FAIL held_rdata cycle %0d got %h ack=%b", i, b1.bus_rdata, b1.bus_ack);
      end
    end
    checks++;
    if (acks !== 1) begin errors++; $display("FAIL held_req_ack_count got %0d exp 1", acks); end
    req = 1'b0;
    repeat (2) @(negedge clk);
    bus_access(1'b0, 16'h2000, 32'd0);
    checks++;
    if (rd1 !== 32'd0 || rd4 !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h/%h exp 0", rd1, rd4); end
    bus_access(1'b1, 16'h2000, 32'h1);
    checks++;
    if (msip1 !== 1'b0) begin errors++; $display("FAIL unmapped_write_msip got %b exp 0", msip1); end
    bus_access(1'b0, 16'h4000, 32'd0);
    checks++;
    if (rd1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmapped_write_cmp got %h exp ffffffff", rd1); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 16'd0; wdata = 32'd0; pin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_timer;
    test_prescaler_wrap;
    test_collision;
    test_msip;
    test_meip;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
